// File: rtl/logit_packer_pkg.sv
// Shared constants and state encoding for the logit packer and its argmax consumer.
// Holds class count, logit width, clamp bounds and the IDLE/COLLECT encoding.
package logit_packer_pkg;

  localparam int NUM_CLASS = 9;
  localparam int LOGIT_W   = 8;

  localparam logic signed [LOGIT_W-1:0] CLAMP_MAX = 8'sd63;
  localparam logic signed [LOGIT_W-1:0] CLAMP_MIN = -8'sd64;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/logit_sat.sv
// Shift-and-clamp of one accumulator score into an 8-bit logit.
// Ports: acc (IN_W signed score in), logit (8-bit two's-complement out).
module logit_sat
  import logit_packer_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 4
) (
  input  logic [IN_W-1:0]    acc,
  output logic [LOGIT_W-1:0] logit
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(CLAMP_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(CLAMP_MIN);

  logic signed [IN_W-1:0] shifted;

  // >>> on a signed operand floors toward minus infinity.
  always_comb begin
    shifted = $signed(acc) >>> SHIFT;
    if (shifted > HI) begin
      logit = CLAMP_MAX;
    end else if (shifted < LO) begin
      logit = CLAMP_MIN;
    end else begin
      logit = shifted[LOGIT_W-1:0];
    end
  end

endmodule

// File: rtl/logit_packer.sv
// Collects NUM_CLASS saturated logits per frame into one packed output word.
// Ports: clk, rst (async high), i_acc/i_acc_valid/i_acc_first in; o_data, o_data_valid, o_frame_err, o_frame_cnt out.
module logit_packer #(
  parameter int NUM_CLASS = logit_packer_pkg::NUM_CLASS,
  parameter int IN_W      = 16,
  parameter int SHIFT     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        i_acc,
  input  logic                   i_acc_valid,
  input  logic                   i_acc_first,
  output logic [8*NUM_CLASS-1:0] o_data,
  output logic                   o_data_valid,
  output logic                   o_frame_err,
  output logic [15:0]            o_frame_cnt
);

  import logit_packer_pkg::*;

  localparam int DW = 8 * NUM_CLASS;
  localparam int CW = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [DW-1:0]     asm_q;
  logic [DW-1:0]     merged;
  logic [LOGIT_W-1:0] logit;
  logic              wr;
  logic [CW-1:0]     slot;
  logic              done;
  logic              err;
  logic              start;
  logic              orphan;
  logic              cont;

  logit_sat #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc   (i_acc),
    .logit (logit)
  );

  assign start  = i_acc_valid && i_acc_first;
  assign orphan = i_acc_valid && !i_acc_first && (state == IDLE);
  assign cont   = i_acc_valid && !i_acc_first && (state == COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (1'b1)
      start: begin
        state_nxt = COLLECT;
        cnt_nxt   = CW'(1);
      end
      cont: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // A first sample mid-frame is both an error and a restart.
  always_comb begin
    wr   = 1'b0;
    slot = '0;
    done = 1'b0;
    err  = 1'b0;
    unique case (1'b1)
      start: begin
        wr  = 1'b1;
        err = (state == COLLECT);
      end
      orphan: err = 1'b1;
      cont: begin
        wr   = 1'b1;
        slot = cnt;
        done = (cnt == LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = asm_q;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (slot == CW'(k)) merged[8*k +: 8] = logit;
    end
  end

  // Restart clears the assembly register so no stale byte can survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_data_valid <= done;
      o_frame_err  <= err;
      if (wr) begin
        asm_q <= start ? DW'(logit) : merged;
      end
      if (done) begin
        o_data      <= merged;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_logit_packer.sv
// Directed bench for logit_packer: saturation table plus framing sequences.
// Drives inputs and samples outputs on the falling clock edge.
module tb_logit_packer;

  localparam int NC = 9;
  localparam int IW = 16;
  localparam int DW = 8 * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] i_acc;
  logic          i_acc_valid;
  logic          i_acc_first;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_frame_err;
  logic [15:0]   o_frame_cnt;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int nboth = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;

  always #5 clk = ~clk;

  logit_packer #(
    .NUM_CLASS (NC),
    .IN_W      (IW),
    .SHIFT     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_acc        (i_acc),
    .i_acc_valid  (i_acc_valid),
    .i_acc_first  (i_acc_first),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_frame_cnt  (o_frame_cnt)
  );

  typedef struct {
    logic [IW-1:0] acc;
    logic [7:0]    exp;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [IW-1:0] a);
    i_acc_valid = v;
    i_acc_first = f;
    i_acc       = a;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (o_data_valid) begin
      nvalid++;
      prev_vcyc = last_vcyc;
      last_vcyc = cyc;
    end
    if (o_frame_err) nerr++;
    if (o_data_valid && o_frame_err) nboth++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input logic [IW-1:0] v[NC], input bit gap);
    for (int k = 0; k < NC; k++) begin
      drive(1'b1, k == 0, v[k]);
      if (gap && k < NC - 1) idle();
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [7:0] b[NC]);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  initial begin
    vec_t          tbl[14];
    logic [IW-1:0] va[NC];
    logic [IW-1:0] vb[NC];
    logic [7:0]    ba[NC];
    logic [7:0]    bb[NC];
    logic [DW-1:0] held;
    int            fc;
    int            e0;
    int            v0;

    tbl[0]  = '{16'h7FFF, 8'h3F};
    tbl[1]  = '{16'h8000, 8'hC0};
    tbl[2]  = '{16'hFFEF, 8'hFE};
    tbl[3]  = '{16'h0000, 8'h00};
    tbl[4]  = '{16'h000F, 8'h00};
    tbl[5]  = '{16'h0010, 8'h01};
    tbl[6]  = '{16'hFFFF, 8'hFF};
    tbl[7]  = '{16'hFFF0, 8'hFF};
    tbl[8]  = '{16'h03F0, 8'h3F};
    tbl[9]  = '{16'h0400, 8'h3F};
    tbl[10] = '{16'h03FF, 8'h3F};
    tbl[11] = '{16'hFC00, 8'hC0};
    tbl[12] = '{16'hFBFF, 8'hC0};
    tbl[13] = '{16'hFC10, 8'hC1};

    rst = 1'b1;
    i_acc_valid = 1'b0;
    i_acc_first = 1'b0;
    i_acc = '0;
    #22;
    check("rst_data", o_data, '0);
    check("rst_valid", DW'(o_data_valid), '0);
    check("rst_err", DW'(o_frame_err), '0);
    check("rst_cnt", DW'(o_frame_cnt), '0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NC; k++) begin
      va[k] = IW'(16 * k);
      ba[k] = 8'(k);
    end
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, va[k]);
    check("hold_during_asm", o_data, '0);
    for (int k = 5; k < NC; k++) drive(1'b1, 1'b0, va[k]);
    check("normal_valid", DW'(o_data_valid), DW'(1));
    check("normal_data", o_data, pack(ba));
    check("normal_cnt", DW'(o_frame_cnt), DW'(1));
    idle();
    check("normal_pulse_end", DW'(o_data_valid), '0);
    check("normal_data_held", o_data, pack(ba));
    fc = 1;

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < NC; k++) begin
        va[k] = tbl[i].acc;
        ba[k] = tbl[i].exp;
      end
      send_frame(va, 1'b0);
      fc++;
      check($sformatf("sat_valid_%0d", i), DW'(o_data_valid), DW'(1));
      check($sformatf("sat_data_%0d", i), o_data, pack(ba));
      idle();
    end
    check("sat_cnt", DW'(o_frame_cnt), DW'(fc));

    held = o_data;
    e0 = nerr;
    drive(1'b1, 1'b0, 16'h0100);
    check("orphan_err", DW'(o_frame_err), DW'(1));
    check("orphan_novalid", DW'(o_data_valid), '0);
    idle();
    check("orphan_err_end", DW'(o_frame_err), '0);
    check("orphan_err_count", DW'(nerr - e0), DW'(1));
    check("orphan_data_held", o_data, held);
    for (int k = 0; k < NC; k++) begin
      va[k] = IW'(32 * k);
      ba[k] = 8'(2 * k);
    end
    send_frame(va, 1'b0);
    fc++;
    check("post_orphan_data", o_data, pack(ba));
    idle();

    e0 = nerr;
    v0 = nvalid;
    drive(1'b1, 1'b1, 16'h0300);
    for (int k = 1; k < 4; k++) drive(1'b1, 1'b0, 16'h0300);
    drive(1'b0, 1'b1, 16'h7FFF);
    for (int k = 0; k < NC; k++) begin
      vb[k] = IW'(-16 * k);
      bb[k] = 8'(-k);
    end
    send_frame(vb, 1'b1);
    fc++;
    check("restart_data", o_data, pack(bb));
    idle();
    check("restart_err_count", DW'(nerr - e0), DW'(1));
    check("restart_valid_count", DW'(nvalid - v0), DW'(1));

    for (int k = 0; k < NC; k++) begin
      va[k] = IW'(16 * (k + 10));
      ba[k] = 8'(k + 10);
      vb[k] = IW'(16 * (63 - k));
      bb[k] = 8'(63 - k);
    end
    e0 = nerr;
    send_frame(va, 1'b0);
    check("b2b_a_data", o_data, pack(ba));
    send_frame(vb, 1'b0);
    fc += 2;
    check("b2b_b_data", o_data, pack(bb));
    check("b2b_spacing", DW'(last_vcyc - prev_vcyc), DW'(9));
    check("b2b_cnt", DW'(o_frame_cnt), DW'(fc));
    check("b2b_no_err", DW'(nerr - e0), '0);
    idle();

    e0 = nerr;
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 16'h0250);
    rst = 1'b1;
    #1;
    check("midrst_data", o_data, '0);
    check("midrst_cnt", DW'(o_frame_cnt), '0);
    check("midrst_valid", DW'(o_data_valid), '0);
    check("midrst_err", DW'(o_frame_err), '0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    check("midrst_no_err", DW'(nerr - e0), '0);
    for (int k = 0; k < NC; k++) begin
      va[k] = IW'(16 * (k + 1));
      ba[k] = 8'(k + 1);
    end
    send_frame(va, 1'b0);
    check("post_rst_valid", DW'(o_data_valid), DW'(1));
    check("post_rst_data", o_data, pack(ba));
    check("post_rst_cnt", DW'(o_frame_cnt), DW'(1));
    idle();

    check("never_both", DW'(nboth), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
